stage_fe: RTL

Instruction fetch stage. Sits directly upstream of the decode stage and feeds it one instruction word per cycle.
- Owns the PC and issues in-order word requests to the instruction memory port.
- Buffers returned words in a small FIFO.
- On flush, redirects the PC and discards stale in-flight responses.
- Decode's stall holds the presented instruction stable.

---
 rtl/stage_fe.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/stage_fe.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to the
// instruction memory, buffers returned words in a small FIFO and presents the
// head entry to decode. A flush redirects the PC, empties the buffer and arms
// a discard counter so that responses still in flight are dropped on arrival.

`ifndef INST_W
`define INST_W 32
`endif

module stage_fe #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
  parameter int                 DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                stall,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [`INST_W-1:0]  imem_rdata,
  output logic                out_valid,
  output logic [`INST_W-1:0]  inst,
  output logic [ADDR_W-1:0]   out_pc
);

  // Counter width covers 0..DEPTH; pointer width indexes DEPTH entries.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]         DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [`INST_W-1:0]  NOP      = `INST_W'(32'h0000_0013);
  localparam logic [ADDR_W-1:0]   WORD_INC = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0]   ALIGN_M  = ~ADDR_W'(2'b11);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      discard_q, discard_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [`INST_W-1:0] word_q [DEPTH];
  logic [ADDR_W-1:0]  bpc_q  [DEPTH];

  logic               credit_ok_s;
  logic               hs_s;
  logic               resp_live_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_dec_s;
  logic [ADDR_W-1:0]  redirect_al_s;

  // Handshake, response and FIFO control strobes.
  always_comb begin
    credit_ok_s   = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
    imem_req      = en && !flush && !rst && credit_ok_s;
    imem_addr     = pc_q;
    hs_s          = imem_req && imem_ready;
    // A response with nothing in flight is a protocol violation; ignore it.
    resp_live_s   = imem_rvalid && (inflight_q != '0);
    push_s        = resp_live_s && !flush && (discard_q == '0);
    drop_dec_s    = resp_live_s && !flush && (discard_q != '0);
    pop_s         = out_valid && en && !stall && !flush;
    redirect_al_s = redirect_pc & ALIGN_M;
  end

  // Next-state computation for PC, counters and FIFO pointers.
  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (flush) begin
      pc_d       = redirect_al_s;
      resp_pc_d  = redirect_al_s;
      // Everything still outstanding after this cycle's response is stale.
      inflight_d = inflight_q - CW'(resp_live_s);
      discard_d  = inflight_q - CW'(resp_live_s);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (hs_s) begin
        pc_d = pc_q + WORD_INC;
      end else begin
        pc_d = pc_q;
      end
      inflight_d = inflight_q + CW'(hs_s) - CW'(resp_live_s);
      if (drop_dec_s) begin
        discard_d = discard_q - CW'(1'b1);
      end else begin
        discard_d = discard_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + WORD_INC;
        wr_ptr_d  = wr_ptr_q + PW'(1'b1);
      end else begin
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage: each live response is written with the PC it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= NOP;
        bpc_q[i]  <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      word_q[wr_ptr_q] <= imem_rdata;
      bpc_q[wr_ptr_q]  <= resp_pc_q;
    end else begin
      word_q[wr_ptr_q] <= word_q[wr_ptr_q];
      bpc_q[wr_ptr_q]  <= bpc_q[wr_ptr_q];
    end
  end

  // Present the buffer head to decode, or a NOP bubble when empty.
  always_comb begin
    out_valid = (count_q != '0);
    if (out_valid) begin
      inst   = word_q[rd_ptr_q];
      out_pc = bpc_q[rd_ptr_q];
    end else begin
      inst   = NOP;
      out_pc = {ADDR_W{1'b0}};
    end
  end

endmodule
